hilo_unit: RTL
==============

# hilo_unit

Multi-cycle multiply sequencer and HI/LO register owner for the MIPS core. It executes MULT, MULTU, MADD, MADDU, MSUB, MSUBU, MTHI and MTLO issued from the execute stage. It stalls MFHI/MFLO reads while an operation is in flight. A radix-2 shift-add datapath is iterated under an FSM, so the execute stage never holds a 32x32 array multiplier.

## Interface
- WIDTH, 32, operand width; HI/LO are WIDTH each; iteration count = WIDTH
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- op_valid  input  1  operation offered this cycle
- op_ready  output  1  unit accepts an operation (high only in IDLE)
- func  input  6  function code, using the codebase MUL/ALU function encodings
- rs_data  input  WIDTH  multiplicand / MTHI/MTLO source
- rt_data  input  WIDTH  multiplier
- hilo_rd  input  1  MFHI/MFLO in execute this cycle
- stall  output  1  = hilo_rd && state != IDLE
- busy  output  1  state != IDLE
- hi, lo  output  WIDTH  registered HI/LO

## Operation
- Accept: op_valid && op_ready at a rising edge.
- MTHI/MTLO: on accept, hi/lo <= rs_data; stays in IDLE.
- Unrecognised func: accepted and dropped; no state change.
- Mul ops:
  - On accept, latch |rs|, |rt| and neg = sign(rs)^sign(rt) for the signed forms; unsigned forms use the raw values with neg = 0.
  - Latch an acc flag (MADD*, MSUB*) and a sub flag (MSUB*).
  - Clear the 2*WIDTH product and the iteration counter.
- FSM:
  - IDLE -> MUL on mul-op accept.
  - MUL: each cycle, if multiplier[0] then product += multiplicand << count; multiplier >>= 1; count++. Leave MUL after iteration WIDTH-1.
  - MUL -> WB: p = neg ? -product : product, all mod 2^(2*WIDTH).
    - Non-acc: {hi,lo} <= p, then go to IDLE.
    - Acc: go to ACC.
  - ACC: {hi,lo} <= {hi,lo} +/- p, mod 2^(2*WIDTH), no overflow trap; then go to IDLE.
- Rounding: WB is merged into the final MUL edge. There is no separate WB cycle.
- rst has priority over everything: state <= IDLE, hi <= 0, lo <= 0, counter and product cleared. This applies mid-operation as well; the in-flight result is lost.
- Output reset values: op_ready=1, busy=0, stall=0, hi=0, lo=0.

## Timing
- Accept edge = cycle 0.
- MUL occupies cycles 1..WIDTH.
- MULT/MULTU: hi/lo valid from cycle WIDTH+1 (33). Unit is IDLE with op_ready=1 in that same cycle.
- MADD/MSUB forms: ACC occupies cycle WIDTH+1. hi/lo are valid and op_ready=1 at cycle WIDTH+2 (34).
- MTHI/MTLO: value visible the cycle after accept.
- Back-to-back: a new op can be accepted in the first IDLE cycle. There is no overlap with completion.
- hilo_rd while busy: stall is high every busy cycle. It drops in the first IDLE cycle, and hi/lo already hold the new result in that cycle.
- hilo_rd and op_valid together in IDLE: no stall. The read sees pre-op hi/lo, and the op is accepted.

## Configuration
- HILO_EARLY_EXIT_EN:
  - Defined: MUL exits after any iteration that leaves the remaining shifted multiplier equal to zero. The minimum is 1 iteration, so a result is visible at cycle k+1, where k = index of the highest set bit of |rt| + 1 (k = 1 when rt = 0).
  - Undefined: always WIDTH iterations.
- Results are identical either way; only latency differs.

## Structure
- Package hilo_pkg:
  - state enum {IDLE, MUL, ACC}
  - a constant holding the counter width, $clog2(WIDTH)
  - an op-class typedef decoded from func: {NONE, MUL, MAC, MTHI, MTLO}, plus the signed and sub flags
- Function codes come from the existing MUL/ALU definition includes; they are not redefined.
- Sub-module mul_step: combinational single shift-add iteration. Inputs: product, multiplicand, multiplier, count. Outputs: next product, next multiplier, done.
- hilo_unit holds the FSM, counter, sign handling, accumulate and HI/LO registers.

## Test plan
- MULTU rs=3, rt=5 -> cycle 33: hi=0x00000000, lo=0x0000000F, op_ready=1; busy=1 during cycles 1..32.
- MULT rs=0xFFFFFFFE (-2), rt=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> cycle 34: hi=0x00000001, lo=0x00000000.
- hi=lo=0, MSUBU 1*1 -> hi=lo=0xFFFFFFFF. MSUB (-1)*(-1) from the same start -> hi=lo=0xFFFFFFFF.
- MULTU with hilo_rd held high -> stall=1 on cycles 1..32, stall=0 on cycle 33 with lo=product. rst pulsed at cycle 10 of a MULT -> next cycle hi=lo=0, op_ready=1, stall=0.
- HILO_EARLY_EXIT_EN defined: MULTU 7*1 -> lo=7 at cycle 2. MULTU 7*0x80000000 -> 32 iterations, hi=0x00000003, lo=0x80000000.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply sequencer.
// Function codes mirror the core's MUL/ALU funct encodings.
package hilo_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [5:0] FUNC_MADD  = 6'h00;
    localparam logic [5:0] FUNC_MADDU = 6'h01;
    localparam logic [5:0] FUNC_MSUB  = 6'h04;
    localparam logic [5:0] FUNC_MSUBU = 6'h05;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } hiloState_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MUL  = 3'd1,
        OP_MAC  = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } opClass_t;

    typedef struct packed {
        opClass_t cls;
        logic     isSigned;
        logic     isSub;
    } opDecode_t;

    function automatic opDecode_t decodeFunc(input logic [5:0] f);
        opDecode_t d;
        d = '{cls: OP_NONE, isSigned: 1'b0, isSub: 1'b0};
        case (f)
            FUNC_MULT:  d = '{cls: OP_MUL,  isSigned: 1'b1, isSub: 1'b0};
            FUNC_MULTU: d = '{cls: OP_MUL,  isSigned: 1'b0, isSub: 1'b0};
            FUNC_MADD:  d = '{cls: OP_MAC,  isSigned: 1'b1, isSub: 1'b0};
            FUNC_MADDU: d = '{cls: OP_MAC,  isSigned: 1'b0, isSub: 1'b0};
            FUNC_MSUB:  d = '{cls: OP_MAC,  isSigned: 1'b1, isSub: 1'b1};
            FUNC_MSUBU: d = '{cls: OP_MAC,  isSigned: 1'b0, isSub: 1'b1};
            FUNC_MTHI:  d = '{cls: OP_MTHI, isSigned: 1'b0, isSub: 1'b0};
            FUNC_MTLO:  d = '{cls: OP_MTLO, isSigned: 1'b0, isSub: 1'b0};
            default:    d = '{cls: OP_NONE, isSigned: 1'b0, isSub: 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (-v) : v;
    endfunction

endpackage

// File: rtl/hilo_unit_mul_step.sv
// One radix-2 shift-add iteration of the HI/LO multiplier.
// HILO_EARLY_EXIT_EN: signal done once the remaining multiplier is zero.
module mul_step
    import hilo_pkg::*;
(
    input  logic [PW-1:0]    product,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [CNT_W-1:0] count,
    output logic [PW-1:0]    nextProduct,
    output logic [WIDTH-1:0] nextMultiplier,
    output logic             done
);

    logic [PW-1:0] addend;

    always_comb begin
        addend = '0;
        if (multiplier[0]) begin
            addend = PW'(multiplicand) << count;
        end
        nextProduct    = product + addend;
        nextMultiplier = multiplier >> 1;
`ifdef HILO_EARLY_EXIT_EN
        done = (count == CNT_W'(WIDTH - 1)) || (nextMultiplier == '0);
`else
        done = (count == CNT_W'(WIDTH - 1));
`endif
    end

endmodule

// File: rtl/hilo_unit.sv
// Multi-cycle multiply/accumulate sequencer and HI/LO register owner.
// Optional HILO_EARLY_EXIT_EN shortens MUL when the multiplier runs out of ones.
module hilo_unit
    import hilo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hilo_rd,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    hiloState_t       state;
    hiloState_t       stateNext;
    opDecode_t        dec;
    logic             accept;
    logic             isMulOp;

    logic [PW-1:0]    product;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [CNT_W-1:0] count;
    logic             negFlag;
    logic             accFlag;
    logic             subFlag;

    logic [PW-1:0]    stepProduct;
    logic [WIDTH-1:0] stepMultiplier;
    logic             stepDone;
    logic [PW-1:0]    finalProduct;

    always_comb begin
        dec     = decodeFunc(func);
        isMulOp = (dec.cls == OP_MUL) || (dec.cls == OP_MAC);
        accept  = op_valid && op_ready;
    end

    mul_step uStep (
        .product        (product),
        .multiplicand   (multiplicand),
        .multiplier     (multiplier),
        .count          (count),
        .nextProduct    (stepProduct),
        .nextMultiplier (stepMultiplier),
        .done           (stepDone)
    );

    // Sign is reapplied on the last MUL edge so no separate writeback cycle exists.
    assign finalProduct = negFlag ? (-stepProduct) : stepProduct;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept && isMulOp) begin
                    stateNext = MUL;
                end
            end
            MUL: begin
                if (stepDone) begin
                    stateNext = accFlag ? ACC : IDLE;
                end
            end
            ACC:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        op_ready = 1'b0;
        busy     = 1'b1;
        stall    = 1'b0;
        if (state == IDLE) begin
            op_ready = 1'b1;
            busy     = 1'b0;
        end
        stall = hilo_rd && busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi           <= '0;
            lo           <= '0;
            product      <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            count        <= '0;
            negFlag      <= 1'b0;
            accFlag      <= 1'b0;
            subFlag      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (dec.cls)
                            OP_MTHI: hi <= rs_data;
                            OP_MTLO: lo <= rs_data;
                            OP_MUL, OP_MAC: begin
                                multiplicand <= dec.isSigned ? absVal(rs_data) : rs_data;
                                multiplier   <= dec.isSigned ? absVal(rt_data) : rt_data;
                                negFlag      <= dec.isSigned && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                accFlag      <= (dec.cls == OP_MAC);
                                subFlag      <= dec.isSub;
                                product      <= '0;
                                count        <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    product    <= stepProduct;
                    multiplier <= stepMultiplier;
                    count      <= count + 1'b1;
                    if (stepDone) begin
                        // Accumulating forms park the signed product for the ACC cycle.
                        if (accFlag) begin
                            product <= finalProduct;
                        end else begin
                            {hi, lo} <= finalProduct;
                        end
                    end
                end
                ACC: begin
                    {hi, lo} <= subFlag ? ({hi, lo} - product) : ({hi, lo} + product);
                end
                default: ;
            endcase
        end
    end

endmodule
